ila_capture_ctrl: RTL and testbench

ILA_CAPTURE_CTRL -- requirements
Module: ila_capture_ctrl

---
 rtl/ila_capture_ctrl_if.sv | 28 ++
 rtl/ila_capture_ctrl.sv | 130 +++++++++++++
 tb/tb_ila_capture_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ila_capture_ctrl_if.sv
// Capture-controller handshake bundle: host controls in, buffer addressing and status out.
// master = host/bench side, slave = controller side.
interface ila_capture_ctrl_if #(
  parameter int AW = 8
);
  logic          arm;
  logic          trig;
  logic          sample_en;
  logic          rd_start;
  logic          rd_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [AW-1:0] trig_addr;
  logic          busy;
  logic          done;

  modport master (
    output arm, trig, sample_en, rd_start, rd_ready,
    input  wr_en, wr_addr, rd_addr, rd_valid, trig_addr, busy, done
  );

  modport slave (
    input  arm, trig, sample_en, rd_start, rd_ready,
    output wr_en, wr_addr, rd_addr, rd_valid, trig_addr, busy, done
  );
endinterface

// File: rtl/ila_capture_ctrl.sv
// Logic-analyser capture controller: circular pre/post-trigger write addressing, then ordered readout.
// ILA_PRETRIG_FILL_EN: when defined, triggers are held off until the pre-trigger window is full.
module ila_capture_ctrl #(
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter int POST_TRIG = 128
) (
  input logic              clk,
  input logic              rst,
  ila_capture_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PRE, POST, DONE, READ} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] POST_W  = (AW+1)'(POST_TRIG);
  localparam logic [AW:0] GATE_W  = (AW+1)'(DEPTH - POST_TRIG);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_addr_q, rd_addr_q, trig_addr_q;
  logic [AW:0]   fill_cnt, post_cnt, rd_cnt;
  logic          gate_open, trig_ok;

`ifdef ILA_PRETRIG_FILL_EN
  assign gate_open = (fill_cnt >= GATE_W);
`else
  assign gate_open = 1'b1;
`endif

  assign trig_ok = (state == PRE) && bus.sample_en && bus.trig && gate_open;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.wr_en    = 1'b0;
    bus.rd_valid = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.arm) state_nxt = PRE;
      end
      PRE: begin
        bus.wr_en = bus.sample_en;
        bus.busy  = 1'b1;
        // The trigger sample is post-sample 1, so POST_TRIG=1 finishes on it.
        if (trig_ok) state_nxt = (POST_TRIG == 1) ? DONE : POST;
      end
      POST: begin
        bus.wr_en = bus.sample_en;
        bus.busy  = 1'b1;
        if (bus.sample_en && (post_cnt == POST_W - ONE_W)) state_nxt = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.arm)           state_nxt = PRE;
        else if (bus.rd_start) state_nxt = READ;
      end
      READ: begin
        bus.rd_valid = 1'b1;
        bus.busy     = 1'b1;
        if (bus.rd_ready && (rd_cnt == DEPTH_W - ONE_W)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      trig_addr_q <= '0;
      fill_cnt    <= '0;
      post_cnt    <= '0;
      rd_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arm) begin
            wr_addr_q <= '0;
            fill_cnt  <= '0;
          end
        end
        PRE: begin
          if (bus.sample_en) begin
            wr_addr_q <= wr_addr_q + 1'b1;
            if (fill_cnt != DEPTH_W) fill_cnt <= fill_cnt + ONE_W;
            if (trig_ok) begin
              trig_addr_q <= wr_addr_q;
              post_cnt    <= ONE_W;
            end
          end
        end
        POST: begin
          if (bus.sample_en) begin
            wr_addr_q <= wr_addr_q + 1'b1;
            post_cnt  <= post_cnt + ONE_W;
          end
        end
        DONE: begin
          if (bus.arm) begin
            wr_addr_q <= '0;
            fill_cnt  <= '0;
          end else if (bus.rd_start) begin
            // wr_addr points at the oldest sample once the capture has closed.
            rd_addr_q <= wr_addr_q;
            rd_cnt    <= '0;
          end
        end
        READ: begin
          if (bus.rd_ready) begin
            rd_addr_q <= rd_addr_q + 1'b1;
            rd_cnt    <= rd_cnt + ONE_W;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_addr   = wr_addr_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.trig_addr = trig_addr_q;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Directed scenarios followed by random traffic, checked each cycle against a sample-count model.
module tb_ila_capture_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PT    = 4;
`ifdef ILA_PRETRIG_FILL_EN
  localparam bit FILL_GATE = 1'b1;
`else
  localparam bit FILL_GATE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  ila_capture_ctrl_if #(.AW(AW)) bus ();

  ila_capture_ctrl #(.DEPTH(DEPTH), .AW(AW), .POST_TRIG(PT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int dut_xfers;

  // Model: phase 0 idle, 1 pre, 2 post, 3 done, 4 read. Addresses derive from sample counts.
  int m_phase   = 0;
  int m_nwr     = 0;
  int m_trig_n  = 0;
  int m_trig    = 0;
  int m_rd_base = 0;
  int m_nrd     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int fill;
    if (rst) begin
      m_phase = 0; m_nwr = 0; m_trig_n = 0; m_trig = 0; m_rd_base = 0; m_nrd = 0;
    end else begin
      case (m_phase)
        0: if (bus.arm) begin m_phase = 1; m_nwr = 0; end
        1: if (bus.sample_en) begin
             fill = (m_nwr < DEPTH) ? m_nwr : DEPTH;
             if (bus.trig && (!FILL_GATE || fill >= DEPTH - PT)) begin
               m_trig_n = m_nwr;
               m_trig   = m_nwr % DEPTH;
               m_phase  = 2;
             end
             m_nwr++;
             if (m_phase == 2 && m_nwr - m_trig_n == PT) m_phase = 3;
           end
        2: if (bus.sample_en) begin
             m_nwr++;
             if (m_nwr - m_trig_n == PT) m_phase = 3;
           end
        3: if (bus.arm) begin
             m_phase = 1; m_nwr = 0;
           end else if (bus.rd_start) begin
             m_phase = 4; m_rd_base = m_nwr % DEPTH; m_nrd = 0;
           end
        4: if (bus.rd_ready) begin
             m_nrd++;
             if (m_nrd == DEPTH) m_phase = 0;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  // Compare every output against the model, advance the model, cross one rising edge.
  task automatic cycle();
    #1;
    check("wr_en", bus.wr_en, ((m_phase == 1 || m_phase == 2) && bus.sample_en) ? 1 : 0);
    check("wr_addr", bus.wr_addr, m_nwr % DEPTH);
    check("rd_addr", bus.rd_addr, (m_rd_base + m_nrd) % DEPTH);
    check("rd_valid", bus.rd_valid, (m_phase == 4) ? 1 : 0);
    check("trig_addr", bus.trig_addr, m_trig);
    check("busy", bus.busy, (m_phase == 1 || m_phase == 2 || m_phase == 4) ? 1 : 0);
    check("done", bus.done, (m_phase == 3) ? 1 : 0);
    if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) dut_xfers++;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic capture16(input int trig_at);
    bus.arm = 1'b1; cycle(); bus.arm = 1'b0;
    bus.sample_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.trig = (i == trig_at);
      cycle();
    end
    bus.trig = 1'b0;
    bus.sample_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.arm = 1'b0; bus.trig = 1'b0; bus.sample_en = 1'b0;
    bus.rd_start = 1'b0; bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 1'b0;
    cycle();

    // Trigger on the 13th sample: four post-samples at 12..15, then done.
    capture16(13);
    #1;
    check("cap_done", bus.done, 1);
    check("cap_wr_addr", bus.wr_addr, 0);
    check("cap_trig_addr", bus.trig_addr, 12);
    cycle();

    // Readout with rd_ready toggling.
    bus.rd_start = 1'b1; cycle(); bus.rd_start = 1'b0;
    dut_xfers = 0;
    for (int i = 0; i < 40; i++) begin
      bus.rd_ready = (i % 2 == 0);
      #1;
      if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1)
        check("rd_seq", bus.rd_addr, dut_xfers % DEPTH);
      cycle();
    end
    bus.rd_ready = 1'b0;
    #1;
    check("rd_xfers", dut_xfers, 16);
    check("rd_end_valid", bus.rd_valid, 0);
    check("rd_end_busy", bus.busy, 0);
    cycle();

    // Early trigger at the 5th sample.
    capture16(5);
    #1;
`ifdef ILA_PRETRIG_FILL_EN
    check("early_trig_addr", bus.trig_addr, 12);
    check("early_busy", bus.busy, 1);
`else
    check("early_trig_addr", bus.trig_addr, 4);
    check("early_done", bus.done, 1);
`endif
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;

    // Trigger without a sample strobe, then wrap while still pre-triggering.
    bus.arm = 1'b1; cycle(); bus.arm = 1'b0;
    bus.trig = 1'b1; cycle(); bus.trig = 1'b0;
    bus.sample_en = 1'b1;
    repeat (20) cycle();
    #1;
    check("wrap_busy", bus.busy, 1);
    check("wrap_wr_addr", bus.wr_addr, 4);
    check("wrap_trig_addr", bus.trig_addr, 0);

    // Reset after two post-samples.
    bus.trig = 1'b1; cycle(); bus.trig = 1'b0;
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    bus.sample_en = 1'b0;
    #1;
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_trig_addr", bus.trig_addr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    cycle();

    // arm and rd_start together in DONE: re-arm wins.
    capture16(13);
    bus.arm = 1'b1; bus.rd_start = 1'b1; cycle();
    bus.arm = 1'b0; bus.rd_start = 1'b0;
    #1;
    check("rearm_busy", bus.busy, 1);
    check("rearm_wr_addr", bus.wr_addr, 0);
    check("rearm_rd_valid", bus.rd_valid, 0);
    repeat (4) cycle();

    // Random traffic.
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom % 97) == 0;
      bus.arm       = ($urandom % 8) == 0;
      bus.trig      = ($urandom % 6) == 0;
      bus.sample_en = ($urandom % 4) != 0;
      bus.rd_start  = ($urandom % 3) == 0;
      bus.rd_ready  = ($urandom % 2) == 0;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
